// File: rtl/bomb_game_fsm.sv
// bomb_game_fsm
// -------------
// Top-level game controller for the bomb puzzle. It holds the bomb logic in
// reset while idle, issues a one-cycle begin_setup pulse to arm it, then runs
// the countdown timer (binary seconds plus BCD m:ss digits) and the strike
// counter until the round is won or the bomb explodes.
//
// Parameters
//   CLK_HZ        vclock cycles per countdown second
//   GAME_SECONDS  round length in seconds (1..599)
//   MAX_STRIKES   strike total that detonates (1..15)
//
// Ports
//   vclock        pixel clock
//   reset_n       asynchronous active-low reset
//   start         single-cycle start / acknowledge pulse
//   strike[3:0]   per-module strike pulses, all set bits count
//   game_won      level from bomb logic, all modules defused
//   begin_setup   one-cycle pulse arming the bomb logic
//   logic_reset   synchronous reset to the bomb logic, high while idle
//   state         0 IDLE, 1 SETUP, 2 ARMED, 3 WON, 4 EXPLODED
//   time_left     seconds remaining, binary
//   min_digit, sec_tens, sec_ones   BCD m:ss of time_left
//   strike_count  strikes so far, saturating at MAX_STRIKES
//   second_tick   one-cycle pulse on each countdown decrement
//   won, exploded high while in WON / EXPLODED
// All outputs come straight from flops.

module bomb_game_fsm #(
  parameter int CLK_HZ       = 65000000,
  parameter int GAME_SECONDS = 300,
  parameter int MAX_STRIKES  = 3
) (
  input  logic       vclock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] strike,
  input  logic       game_won,
  output logic       begin_setup,
  output logic       logic_reset,
  output logic [2:0] state,
  output logic [9:0] time_left,
  output logic [3:0] min_digit,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] strike_count,
  output logic       second_tick,
  output logic       won,
  output logic       exploded
);

  // A one-cycle-per-second design still needs a 1-bit prescaler.
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_HZ - 1);
  localparam logic [9:0]    TIME_INIT   = 10'(GAME_SECONDS);
  localparam logic [3:0]    MIN_INIT    = 4'(GAME_SECONDS / 60);
  localparam logic [3:0]    TENS_INIT   = 4'((GAME_SECONDS % 60) / 10);
  localparam logic [3:0]    ONES_INIT   = 4'(GAME_SECONDS % 10);
  localparam logic [4:0]    STRIKE_MAX  = 5'(MAX_STRIKES);
  localparam logic [3:0]    STRIKE_SAT  = 4'(MAX_STRIKES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_ARMED    = 3'd2,
    ST_WON      = 3'd3,
    ST_EXPLODED = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [9:0]      time_q, time_d;
  logic [3:0]      min_q, min_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic [3:0]      strikes_q, strikes_d;
  logic            tick_q, tick_d;
  logic            begin_setup_q, begin_setup_d;
  logic            logic_reset_q, logic_reset_d;
  logic            won_q, won_d;
  logic            exploded_q, exploded_d;
  logic [4:0]      strike_total;

  // Next-state and datapath logic. The 5-bit strike total leaves headroom so
  // several simultaneous strikes on top of MAX_STRIKES-1 cannot wrap before
  // the saturation compare.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    time_d    = time_q;
    min_d     = min_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    strikes_d = strikes_q;
    tick_d    = 1'b0;

    strike_total = {1'b0, strikes_q} + 5'(strike[0]) + 5'(strike[1])
                 + 5'(strike[2]) + 5'(strike[3]);

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (game_won) begin
          // Win beats everything: no strike, tick or timer update this cycle.
          state_d = ST_WON;
        end else if (strike_total >= STRIKE_MAX) begin
          // Strike is recorded (saturated) but the timer is frozen.
          strikes_d = STRIKE_SAT;
          state_d   = ST_EXPLODED;
        end else begin
          strikes_d = strike_total[3:0];
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (time_q != 10'd0) begin
              tick_d = 1'b1;
              time_d = time_q - 10'd1;
              // BCD digits borrow in lockstep with the binary count.
              if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
              end else begin
                ones_d = 4'd9;
                if (tens_q != 4'd0) begin
                  tens_d = tens_q - 4'd1;
                end else begin
                  tens_d = 4'd5;
                  min_d  = min_q - 4'd1;
                end
              end
              if (time_q == 10'd1) state_d = ST_EXPLODED;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      ST_WON, ST_EXPLODED: begin
        if (start) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering or staying in IDLE reloads the round so the display shows the
    // fresh time as soon as the controller is back in IDLE.
    if (state_d == ST_IDLE) begin
      presc_d   = '0;
      time_d    = TIME_INIT;
      min_d     = MIN_INIT;
      tens_d    = TENS_INIT;
      ones_d    = ONES_INIT;
      strikes_d = '0;
    end

    // Status outputs are decoded from the next state so they are registered
    // and line up with the state they describe.
    begin_setup_d = (state_d == ST_SETUP);
    logic_reset_d = (state_d == ST_IDLE);
    won_d         = (state_d == ST_WON);
    exploded_d    = (state_d == ST_EXPLODED);
  end

  // State and datapath registers with asynchronous reset to the idle round.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      presc_q       <= '0;
      time_q        <= TIME_INIT;
      min_q         <= MIN_INIT;
      tens_q        <= TENS_INIT;
      ones_q        <= ONES_INIT;
      strikes_q     <= '0;
      tick_q        <= 1'b0;
      begin_setup_q <= 1'b0;
      logic_reset_q <= 1'b1;
      won_q         <= 1'b0;
      exploded_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      time_q        <= time_d;
      min_q         <= min_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      strikes_q     <= strikes_d;
      tick_q        <= tick_d;
      begin_setup_q <= begin_setup_d;
      logic_reset_q <= logic_reset_d;
      won_q         <= won_d;
      exploded_q    <= exploded_d;
    end
  end

  assign state        = state_q;
  assign time_left    = time_q;
  assign min_digit    = min_q;
  assign sec_tens     = tens_q;
  assign sec_ones     = ones_q;
  assign strike_count = strikes_q;
  assign second_tick  = tick_q;
  assign begin_setup  = begin_setup_q;
  assign logic_reset  = logic_reset_q;
  assign won          = won_q;
  assign exploded     = exploded_q;

endmodule

// File: doc/bomb_game_fsm.md
# bomb_game_fsm

Top-level game controller that drives the bomb logic block. It holds the bomb logic in reset while idle and issues the one-cycle `begin_setup` pulse that arms it. It then runs the countdown timer and strike counter, and resolves each round as won, on `game_won`, or exploded, on timeout or too many strikes. It sits beside the bomb logic on the 65 MHz pixel clock and feeds the timer digits and strike count to the display path.

## Interface
- `CLK_HZ`, 65000000, vclock cycles per countdown second
- `GAME_SECONDS`, 300, round length in seconds; legal range 1..599
- `MAX_STRIKES`, 3, strike total that detonates; legal range 1..15
- `vclock`  in  1  65 MHz clock
- `reset_n`  in  1  one clock; reset is asynchronous and active-low
- `start`  in  1  single-cycle debounced start/acknowledge pulse
- `strike`  in  4  per-module single-cycle strike pulses (bit i = module i)
- `game_won`  in  1  level from bomb logic; all modules defused
- `begin_setup`  out  1  one-cycle pulse to bomb logic
- `logic_reset`  out  1  active-high synchronous reset to bomb logic
- `state`  out  3  0 IDLE, 1 SETUP, 2 ARMED, 3 WON, 4 EXPLODED
- `time_left`  out  10  seconds remaining, binary
- `min_digit`, `sec_tens`, `sec_ones`  out  4 each  BCD m:ss of `time_left`
- `strike_count`  out  4  strikes accumulated; saturates at MAX_STRIKES
- `second_tick`  out  1  one-cycle pulse on each countdown decrement
- `won`, `exploded`  out  1 each  high while in WON / EXPLODED

## Operation
- Reset values:
  - state IDLE, `logic_reset`=1, `begin_setup`=0, `second_tick`=0, `won`=0, `exploded`=0.
  - `time_left`=GAME_SECONDS with matching BCD digits (300 → 5,0,0), `strike_count`=0, prescaler=0.
- IDLE:
  - `logic_reset`=1; timer reloaded to GAME_SECONDS; strikes cleared; prescaler cleared.
  - `start` → SETUP.
- SETUP, exactly one cycle:
  - `logic_reset`=0, `begin_setup`=1.
  - Unconditionally → ARMED.
- ARMED:
  - Prescaler counts 0..CLK_HZ-1 and wraps.
  - On wrap: `second_tick`=1 that cycle; `time_left` decrements by 1; BCD digits decrement in lockstep with borrow (x:00 → (x-1):59).
  - Strikes: the popcount of `strike` is added to `strike_count` each cycle. Simultaneous bits all count. The result saturates at MAX_STRIKES.
- Exit priority in ARMED, evaluated per cycle from highest:
  1. `game_won`=1 → WON. Strike, tick and timer updates are suppressed that cycle.
  2. Updated strike total ≥ MAX_STRIKES → EXPLODED. The strike update is taken; the timer is frozen.
  3. Tick taking `time_left` from 1 to 0 → EXPLODED on the same edge. `time_left` reads 0.
- WON / EXPLODED:
  - Timer, prescaler and strikes are frozen.
  - `strike` and `game_won` are ignored.
  - `logic_reset` stays 0, so the bomb logic display persists.
  - `start` → IDLE, never directly to SETUP.
- `start` is ignored in SETUP and ARMED.
- `strike` is ignored outside ARMED.
- `reset_n` low at any time, mid-countdown included, forces all reset values immediately; the next `start` begins a fresh round.
- `time_left` never underflows below 0; `strike_count` never exceeds MAX_STRIKES.

## Timing
- `start` sampled high at edge t: SETUP from t+1, `begin_setup` high for cycles t+1..t+2, ARMED from t+2.
- `logic_reset` is high through edge t+1 and low from t+1. The bomb logic's sticky `game_won` is therefore cleared before ARMED.
- First `second_tick` falls CLK_HZ cycles after ARMED entry; ticks then repeat every CLK_HZ cycles.
- All outputs are registered. Transitions take effect on the edge following the qualifying input; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use CLK_HZ=10, GAME_SECONDS=3, MAX_STRIKES=3 unless noted.
- **Reset and arm:** deassert `reset_n`, pulse `start` → `begin_setup` high exactly one cycle, one cycle after start. `state` goes 0→1→2. `logic_reset` drops with SETUP. `time_left`=3.
- **Timeout:** arm, apply no strikes and no `game_won` → `second_tick` every 10 cycles, `time_left` 3→2→1→0. `state`=4 and `exploded`=1 on the third tick edge. The timer stays 0 afterwards.
- **Strikes:** arm, pulse `strike`=4'b0001, then `strike`=4'b0110 in one cycle → `strike_count` 1 then 3, EXPLODED on the second pulse's edge. A further `strike` leaves the count at 3.
- **Win priority:** in one ARMED cycle, drive `game_won`=1 with `strike`=4'b0011 while `strike_count`=1 → WON, `strike_count` stays 1, `exploded`=0.
- **BCD borrow:** with GAME_SECONDS=61, arm and wait 2 ticks → digits 1:01 → 1:00 → 0:59, `time_left` 59.
- **Mid-round reset and replay:** assert `reset_n` low during ARMED → IDLE, `time_left`=GAME_SECONDS, `strike_count`=0. In WON, `start` → IDLE; a second `start` → new SETUP pulse.
